// File: rtl/shreg_load_ctrl_if.sv
// Parallel-side bundle for shreg_load_ctrl: producer handshake, status and readback word.
// The master modport is the producer; the slave modport is the controller.
interface shreg_load_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             busy;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  busy,
    input  dout,
    input  dout_valid
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output busy,
    output dout,
    output dout_valid
  );
endinterface

// File: rtl/shreg_load_ctrl.sv
// Loads one parallel word per handshake into a serial shift chain, MSB first, then latches it.
// Define SHREG_CTRL_READBACK_EN to capture the chain's serial return (sin) into dout.
module shreg_load_ctrl #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned CLKDIV = 2
) (
  input  logic              clk,
  input  logic              nRST,
  shreg_load_ctrl_if.slave  bus,
  output logic              sdata,
  output logic              sclk,
  output logic              slatch,
  input  logic              sin
);

  localparam int unsigned DivW = $clog2(CLKDIV) + 1;
  localparam int unsigned BitW = $clog2(WIDTH);
  localparam logic [DivW-1:0] DivMax = DivW'(CLKDIV - 1);
  localparam logic [BitW-1:0] BitMax = BitW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0] shbuf_q, shbuf_d;
  logic             sdata_q, sdata_d;
  logic             sclk_q, sclk_d;
  logic             slatch_q, slatch_d;

  logic div_end;
  logic accept;
  logic sclk_rise;
  logic latch_done;

  assign div_end    = (div_q == DivMax);
  assign accept     = (state_q == StIdle) && bus.din_valid;
  assign sclk_rise  = (state_q == StShift) && div_end && !sclk_q;
  assign latch_done = (state_q == StLatch) && div_end;

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q  <= StIdle;
      div_q    <= '0;
      bit_q    <= '0;
      shbuf_q  <= '0;
      sdata_q  <= 1'b0;
      sclk_q   <= 1'b0;
      slatch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shbuf_q  <= shbuf_d;
      sdata_q  <= sdata_d;
      sclk_q   <= sclk_d;
      slatch_q <= slatch_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shbuf_d  = shbuf_q;
    sdata_d  = sdata_q;
    sclk_d   = sclk_q;
    slatch_d = slatch_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // MSB goes straight onto sdata; the buffer keeps the remaining bits left-aligned.
          state_d = StShift;
          shbuf_d = bus.din << 1;
          sdata_d = bus.din[WIDTH-1];
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      StShift: begin
        if (!div_end) begin
          div_d = div_q + DivW'(1);
        end else begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BitMax) begin
              state_d  = StLatch;
              slatch_d = 1'b1;
            end else begin
              bit_d   = bit_q + BitW'(1);
              sdata_d = shbuf_q[WIDTH-1];
              shbuf_d = shbuf_q << 1;
            end
          end
        end
      end
      StLatch: begin
        if (!div_end) begin
          div_d = div_q + DivW'(1);
        end else begin
          div_d    = '0;
          state_d  = StIdle;
          slatch_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.din_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign sdata         = sdata_q;
  assign sclk          = sclk_q;
  assign slatch        = slatch_q;

`ifdef SHREG_CTRL_READBACK_EN
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;

  always_ff @(posedge clk) begin
    if (!nRST) begin
      rb_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      rb_q         <= rb_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // sin is taken on the edge that raises sclk, i.e. before the chain shifts on that rise.
  always_comb begin
    rb_d         = rb_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (accept) begin
      rb_d = '0;
    end else if (sclk_rise) begin
      rb_d = {rb_q[WIDTH-2:0], sin};
    end
    if (latch_done) begin
      dout_d       = rb_q;
      dout_valid_d = 1'b1;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
`else
  logic unused_sin;
  logic unused_rb_strobes;
  assign unused_sin        = sin;
  assign unused_rb_strobes = sclk_rise ^ latch_done;

  assign bus.dout       = '0;
  assign bus.dout_valid = 1'b0;
`endif

endmodule

// File: tb/tb_shreg_load_ctrl.sv
// Directed bench for shreg_load_ctrl: default 16-bit/div-2 instance with a modelled shift
// chain on sin, plus a 4-bit/div-1 instance for the fastest timing case.
module tb_shreg_load_ctrl;

  localparam int C0 = 2;

`ifdef SHREG_CTRL_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic nRST;
  always #5 clk = ~clk;

  shreg_load_ctrl_if #(.WIDTH(16)) bus0 ();
  shreg_load_ctrl_if #(.WIDTH(4))  bus1 ();
  logic sdata0, sclk0, slatch0, sin0;
  logic sdata1, sclk1, slatch1;
  logic sin1 = 1'b0;

  shreg_load_ctrl #(.WIDTH(16), .CLKDIV(2)) dut0 (
    .clk    (clk),
    .nRST   (nRST),
    .bus    (bus0),
    .sdata  (sdata0),
    .sclk   (sclk0),
    .slatch (slatch0),
    .sin    (sin0)
  );

  shreg_load_ctrl #(.WIDTH(4), .CLKDIV(1)) dut1 (
    .clk    (clk),
    .nRST   (nRST),
    .bus    (bus1),
    .sdata  (sdata1),
    .sclk   (sclk1),
    .slatch (slatch1),
    .sin    (sin1)
  );

  // 16-stage chain on dut0: shifts once per sclk rise, end stage feeds sin0.
  logic [15:0] chain;
  logic [15:0] chain_init;
  logic        chain_load;
  logic        sclk_prev;
  always @(posedge clk) begin
    sclk_prev <= sclk0;
    if (chain_load) chain <= chain_init;
    else if (sclk0 && !sclk_prev) chain <= {chain[14:0], sdata0};
  end
  assign sin0 = chain[15];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic preload_chain(input logic [15:0] val);
    chain_init = val;
    chain_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chain_load = 1'b0;
  endtask

  // Called just after a negedge with dut0 idle; returns on the negedge of the first IDLE cycle.
  task automatic run_xfer(input logic [15:0] word, input bit keep,
                          output logic [15:0] cap, output int rises, output int bad,
                          output int lat_first, output int lat_len, output int rdy_at,
                          output logic dv_at_rdy, output logic [15:0] dout_at_rdy,
                          output logic [4:0] k1);
    logic prev_sclk, prev_sdata;
    bus0.din = word;
    bus0.din_valid = 1'b1;
    cap = '0; rises = 0; bad = 0; lat_first = -1; lat_len = 0; rdy_at = -1;
    dv_at_rdy = 1'b0; dout_at_rdy = '0; k1 = '0;
    prev_sclk = 1'b0; prev_sdata = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (k == 1) begin
        k1 = {bus0.busy, bus0.din_ready, sclk0, sdata0, bus0.dout_valid};
        if (!keep) bus0.din_valid = 1'b0;
      end
      if (sclk0 && !prev_sclk) begin
        if (k != 1 + C0 + 2 * C0 * rises) bad++;
        cap = {cap[14:0], sdata0};
        rises++;
      end
      if (sclk0 && prev_sclk && (sdata0 != prev_sdata)) bad++;
      prev_sclk  = sclk0;
      prev_sdata = sdata0;
      if (slatch0) begin
        if (lat_first < 0) lat_first = k;
        lat_len++;
      end
      if (bus0.din_ready) begin
        rdy_at      = k;
        dv_at_rdy   = bus0.dout_valid;
        dout_at_rdy = bus0.dout;
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] din;
    bit          keep;
    logic [15:0] exp_cap;
    logic [15:0] exp_rb;
  } vec_t;

  vec_t vecs [5];

  task automatic check_xfer(input string tag, input logic [15:0] exp_cap,
                            input logic [15:0] exp_rb, input logic [15:0] cap, input int rises,
                            input int bad, input int lat_first, input int lat_len,
                            input int rdy_at, input logic dv, input logic [15:0] dout,
                            input logic [4:0] k1);
    chk({tag, " state@T0+1"}, {27'd0, k1}, {27'd0, 1'b1, 1'b0, 1'b0, exp_cap[15], 1'b0});
    chk({tag, " word"}, {16'd0, cap}, {16'd0, exp_cap});
    chk({tag, " rises"}, rises, 16);
    chk({tag, " timing"}, bad, 0);
    chk({tag, " latch start"}, lat_first, 65);
    chk({tag, " latch len"}, lat_len, 2);
    chk({tag, " ready at"}, rdy_at, 67);
    chk({tag, " dout_valid"}, {31'd0, dv}, {31'd0, RB});
    chk({tag, " dout"}, {16'd0, dout}, RB ? {16'd0, exp_rb} : 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1);
  end

  initial begin : main
    logic [15:0] cap, dout;
    int          rises, bad, lat_first, lat_len, rdy_at, cnt_latch, cnt_busy;
    logic        dv;
    logic [4:0]  k1;
    logic [3:0]  cap1;

    // Chain contents seen by each transfer's readback are the previous word shifted in.
    vecs[0] = '{din: 16'hA5C3, keep: 1'b1, exp_cap: 16'hA5C3, exp_rb: 16'h1234};
    vecs[1] = '{din: 16'h3C96, keep: 1'b0, exp_cap: 16'h3C96, exp_rb: 16'hA5C3};
    vecs[2] = '{din: 16'hFFFF, keep: 1'b1, exp_cap: 16'hFFFF, exp_rb: 16'h3C96};
    vecs[3] = '{din: 16'h8001, keep: 1'b0, exp_cap: 16'h8001, exp_rb: 16'hFFFF};
    vecs[4] = '{din: 16'h0000, keep: 1'b0, exp_cap: 16'h0000, exp_rb: 16'h8001};

    nRST = 1'b0;
    bus0.din = '0; bus0.din_valid = 1'b0;
    bus1.din = '0; bus1.din_valid = 1'b0;
    chain_init = 16'h1234; chain_load = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chain_load = 1'b0;
    chk("reset dut0 outputs", {bus0.din_ready, bus0.busy, sdata0, sclk0, slatch0,
        bus0.dout_valid}, 6'b100000);
    chk("reset dut0 dout", {16'd0, bus0.dout}, 32'd0);
    chk("reset dut1 outputs", {bus1.din_ready, bus1.busy, sdata1, sclk1, slatch1,
        bus1.dout_valid}, 6'b100000);
    nRST = 1'b1;
    @(negedge clk);
    chk("ready after reset", {31'd0, bus0.din_ready}, 32'd1);

    for (int i = 0; i < 5; i++) begin
      run_xfer(vecs[i].din, vecs[i].keep, cap, rises, bad, lat_first, lat_len, rdy_at, dv,
               dout, k1);
      check_xfer($sformatf("vec%0d", i), vecs[i].exp_cap, vecs[i].exp_rb, cap, rises, bad,
                 lat_first, lat_len, rdy_at, dv, dout, k1);
    end
    @(negedge clk);
    chk("dout_valid single cycle", {31'd0, bus0.dout_valid}, 32'd0);

    // WIDTH=4, CLKDIV=1: sclk toggles every cycle.
    bus1.din = 4'b1001;
    bus1.din_valid = 1'b1;
    cap1 = '0; rises = 0; bad = 0; lat_first = -1; lat_len = 0; rdy_at = -1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus1.din_valid = 1'b0;
      if (k <= 8 && (sclk1 != ((k % 2) == 0))) bad++;
      if (sclk1 && (k % 2) == 0) begin
        cap1 = {cap1[2:0], sdata1};
        rises++;
      end
      if (slatch1) begin
        if (lat_first < 0) lat_first = k;
        lat_len++;
      end
      if (bus1.din_ready) begin
        rdy_at = k;
        break;
      end
    end
    chk("w4 word", {28'd0, cap1}, 32'h9);
    chk("w4 rises", rises, 4);
    chk("w4 toggle", bad, 0);
    chk("w4 latch start", lat_first, 9);
    chk("w4 latch len", lat_len, 1);
    chk("w4 ready at", rdy_at, 10);
    chk("w4 dout", {28'd0, bus1.dout}, 32'd0);

    // Reset at cycle 20 of a transfer, while sclk is high and sdata=1.
    @(negedge clk);
    bus0.din = 16'h5A0F;
    bus0.din_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) bus0.din_valid = 1'b0;
    end
    chk("pre-abort sclk/sdata", {30'd0, sclk0, sdata0}, 32'd3);
    nRST = 1'b0;
    @(negedge clk);
    chk("abort outputs", {bus0.din_ready, bus0.busy, sdata0, sclk0, slatch0,
        bus0.dout_valid}, 6'b100000);
    nRST = 1'b1;
    cnt_latch = 0; cnt_busy = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (slatch0) cnt_latch++;
      if (!bus0.din_ready || bus0.busy) cnt_busy++;
    end
    chk("abort no latch", cnt_latch, 0);
    chk("abort stays idle", cnt_busy, 0);

    preload_chain(16'h1234);
    run_xfer(16'hA5C3, 1'b0, cap, rises, bad, lat_first, lat_len, rdy_at, dv, dout, k1);
    check_xfer("post-abort", 16'hA5C3, 16'h1234, cap, rises, bad, lat_first, lat_len, rdy_at,
               dv, dout, k1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shreg_load_ctrl.md
# shreg_load_ctrl

Sequencer that loads a parallel word into an external or on-chip serial shift-register chain built from GP_SHREG / DFF stages. It accepts one word per valid/ready handshake, shifts it out MSB-first on a generated shift clock, then pulses a latch strobe. It sits between a parallel producer and the shift chain, and is the only driver of the chain's data, clock and latch nets.

## Interface
- WIDTH, 16, bits per word and number of shift-clock pulses per transfer (2..32)
- CLKDIV, 2, clk cycles per sclk half-period (>=1)
- clk  in  1  system clock; all logic on posedge
- nRST  in  1  synchronous, active-low reset
- din  in  WIDTH  word to shift; sampled only on handshake
- din_valid  in  1  producer has a word
- din_ready  out  1  controller idle and able to accept
- busy  out  1  transfer in progress (SHIFT or LATCH)
- sdata  out  1  serial data to chain input
- sclk  out  1  shift clock to chain; chain samples on rising edge
- slatch  out  1  latch/transfer strobe, high for CLKDIV cycles
- sin  in  1  serial return from chain end (used only with readback)
- dout  out  WIDTH  word shifted back from chain (readback only)
- dout_valid  out  1  one-cycle pulse when dout is updated (readback only)

## Operation
- Reset (nRST low at a clk edge): state IDLE; sdata=0, sclk=0, slatch=0, busy=0, dout=0, dout_valid=0; bit and divider counters cleared. din_ready=1 in IDLE, including the first cycle after reset.
- States: IDLE -> SHIFT on din_valid & din_ready; SHIFT -> LATCH after bit WIDTH-1 completes its high phase; LATCH -> IDLE after CLKDIV cycles.
- Handshake: transfer occurs on the clk edge where din_valid & din_ready; din captured into a shift buffer. din_valid while busy is ignored, with no loss of a pending word; the producer holds it.
- SHIFT: each bit = CLKDIV cycles sclk low followed by CLKDIV cycles sclk high. sdata changes only when sclk goes low, or on SHIFT entry. MSB (din[WIDTH-1]) first.
- LATCH: sclk=0, sdata holds last bit, slatch=1 for CLKDIV cycles.
- Divider counter: width clog2(CLKDIV)+1, wraps to 0 at CLKDIV-1. Bit counter: 0..WIDTH-1, no wrap past WIDTH-1.
- Reset mid-transfer: aborts immediately; no slatch pulse; the partial word is discarded.

## Timing
- Handshake edge T0. At T0+1: busy=1, din_ready=0, sdata=din[WIDTH-1], sclk=0.
- Rising sclk for bit i (i=0 is MSB) at T0+1+CLKDIV+2·CLKDIV·i.
- slatch high from T0+1+2·CLKDIV·WIDTH for CLKDIV cycles.
- din_ready=1 and busy=0 at T0+1+2·CLKDIV·WIDTH+CLKDIV. Defaults: 67 cycles.
- Back-to-back: next handshake can occur on the first IDLE cycle; there are no idle gap cycles beyond that.

## Configuration
- SHREG_CTRL_READBACK_EN defined: sin sampled on each clk edge where sclk rises, shifted into dout MSB-first. dout_valid pulses for one cycle on the LATCH->IDLE edge, with dout holding the WIDTH returned bits.
- Undefined: readback logic absent; dout=0, dout_valid=0 constantly; sin ignored.

## Test plan
- Reset, then din=16'hA5C3 with din_valid held: sdata sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 at the 16 sclk rises; slatch high cycles 65-66 after handshake; din_ready back at cycle 67.
- CLKDIV=1, WIDTH=4, din=4'b1001: sclk toggles every cycle; 4 rises; slatch 1 cycle; din_ready returns 10 cycles after handshake.
- din_valid asserted continuously with two words: second handshake exactly on first IDLE cycle; no gap beyond that; second word shifted intact.
- nRST low at cycle 20 of a transfer: the next cycle has sclk=0, sdata=0, slatch never asserted; din_ready=1; a new word then shifts correctly.
- READBACK_EN, sin looped to a 16-stage chain preloaded 16'h1234: after load, dout=16'h1234 with a single-cycle dout_valid on the LATCH->IDLE edge.
- Without READBACK_EN: dout=0 and dout_valid=0 across full transfers with sin toggling.
